// File: rtl/proc_argmax_seq_pkg.sv
// Shared definitions for the argmax scanner.
//   state_e    : scanner FSM states
//   NDATA_DEF  : default number of entries scanned
//   LANE_W     : entry value width (index width + 1) for the default size
package proc_argmax_seq_pkg;

  localparam int unsigned NDATA_DEF     = 128;
  localparam int unsigned NDATA_LOG_DEF = $clog2(NDATA_DEF);
  localparam int unsigned LANE_W        = NDATA_LOG_DEF + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/proc_comp.sv
// 4-input unsigned maximum selector.
//   data_i     : four lanes of W bits, lane k in bits [(k+1)*W-1 : k*W]
//   max_val_o  : largest lane value
//   max_lane_o : lane holding that value; ties resolve to the lowest lane
module proc_comp
  import proc_argmax_seq_pkg::*;
#(
  parameter int unsigned W = LANE_W
) (
  input  logic [4*W-1:0] data_i,
  output logic [W-1:0]   max_val_o,
  output logic [1:0]     max_lane_o
);

  logic [W-1:0] v [4];
  logic [W-1:0] lo_v, hi_v;
  logic         lo_l, hi_l;

  // Each stage only moves to the higher lane on a strict win, so equal
  // values always keep the lower lane.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) v[k] = data_i[k*W +: W];

    if (v[1] > v[0]) begin lo_v = v[1]; lo_l = 1'b1; end
    else             begin lo_v = v[0]; lo_l = 1'b0; end

    if (v[3] > v[2]) begin hi_v = v[3]; hi_l = 1'b1; end
    else             begin hi_v = v[2]; hi_l = 1'b0; end

    if (hi_v > lo_v) begin
      max_val_o  = hi_v;
      max_lane_o = {1'b1, hi_l};
    end else begin
      max_val_o  = lo_v;
      max_lane_o = {1'b0, lo_l};
    end
  end

endmodule

// File: rtl/proc_argmax_seq.sv
// Sequential argmax over an entry memory read four entries per cycle.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   start    : request a scan (only honoured in IDLE)
//   busy     : scan in progress (READ and DRAIN)
//   rdEn     : group read strobe; rdAddr group address (0 when idle)
//   rdData   : group data, valid the cycle after rdEn
//   done     : one-cycle pulse, maxIdx/maxVal valid
//   maxIdx   : index of the largest entry (lowest index on ties)
//   maxVal   : value of the largest entry
module proc_argmax_seq
  import proc_argmax_seq_pkg::*;
#(
  parameter int unsigned NDATA     = NDATA_DEF,
  parameter int unsigned NDATA_LOG = $clog2(NDATA)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       rdEn,
  output logic [NDATA_LOG-3:0]       rdAddr,
  input  logic [4*(NDATA_LOG+1)-1:0] rdData,
  output logic                       done,
  output logic [NDATA_LOG-1:0]       maxIdx,
  output logic [NDATA_LOG:0]         maxVal
);

  localparam int unsigned VW = NDATA_LOG + 1;
  localparam int unsigned CW = NDATA_LOG - 2;
  localparam logic [CW-1:0] LAST_GRP = CW'(NDATA/4 - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        addr_q;
  logic                 vld_q;
  logic                 clr;
  logic [VW-1:0]        grp_val;
  logic [1:0]           grp_lane;
  logic [VW-1:0]        best_val_q, best_val_d;
  logic [NDATA_LOG-1:0] best_idx_q, best_idx_d;
  logic [VW-1:0]        res_val_q;
  logic [NDATA_LOG-1:0] res_idx_q;

  proc_comp #(.W(VW)) u_comp (
    .data_i     (rdData),
    .max_val_o  (grp_val),
    .max_lane_o (grp_lane)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdEn    = 1'b0;
    rdAddr  = '0;
    busy    = 1'b0;
    done    = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      S_READ: begin
        rdEn   = 1'b1;
        rdAddr = cnt_q;
        busy   = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_GRP) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strictly-greater replacement keeps the earliest group on global ties.
  always_comb begin
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    if (clr) begin
      best_val_d = '0;
      best_idx_d = '0;
    end else if (vld_q && (grp_val > best_val_q)) begin
      best_val_d = grp_val;
      best_idx_d = {addr_q, grp_lane};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      vld_q      <= 1'b0;
      best_val_q <= '0;
      best_idx_q <= '0;
      res_val_q  <= '0;
      res_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= rdAddr;
      vld_q      <= rdEn;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      // The last group is absorbed in DRAIN; loading the result from the
      // next-state value lets it appear together with the done pulse.
      if (state_q == S_DRAIN) begin
        res_val_q <= best_val_d;
        res_idx_q <= best_idx_d;
      end
    end
  end

  assign maxIdx = res_idx_q;
  assign maxVal = res_val_q;

endmodule

// File: tb/tb_proc_argmax_seq.sv
module tb_proc_argmax_seq;

  localparam int unsigned NDATA = 128;
  localparam int unsigned NL    = 7;
  localparam int unsigned VW    = 8;
  localparam int          NG    = 32;

  logic            clk = 1'b0;
  logic            rst, start;
  logic            busy, rdEn, done;
  logic [NL-3:0]   rdAddr;
  logic [4*VW-1:0] rdData;
  logic [NL-1:0]   maxIdx;
  logic [VW-1:0]   maxVal;

  logic [VW-1:0] mem [NDATA];
  int n_chk  = 0;
  int n_fail = 0;
  logic [NL-1:0] prev_idx;
  logic [VW-1:0] prev_val;

  typedef struct {
    string         name;
    int            pattern;
    int            pulse_at;
    logic [NL-1:0] eidx;
    logic [VW-1:0] eval;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  proc_argmax_seq #(.NDATA(NDATA)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .busy   (busy),
    .rdEn   (rdEn),
    .rdAddr (rdAddr),
    .rdData (rdData),
    .done   (done),
    .maxIdx (maxIdx),
    .maxVal (maxVal)
  );

  // Entry memory: one-cycle read latency, four entries per group.
  always @(posedge clk) begin
    if (rdEn) begin
      for (int k = 0; k < 4; k++) rdData[k*VW +: VW] <= mem[4*int'(rdAddr) + k];
    end else begin
      rdData <= '0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fill(input int p);
    for (int i = 0; i < NDATA; i++) begin
      case (p)
        0: mem[i] = '0;
        1: mem[i] = VW'(i);
        2: mem[i] = 8'd3;
        3: mem[i] = 8'd1;
        4: mem[i] = VW'($urandom_range(0, 254));
        5: mem[i] = 8'd255;
        6: mem[i] = '0;
        7: mem[i] = '0;
        default: mem[i] = '0;
      endcase
    end
    case (p)
      2: mem[77] = 8'd200;
      3: begin mem[40] = 8'd250; mem[41] = 8'd250; end
      4: begin mem[5] = 8'd255; mem[90] = 8'd255; end
      6: mem[127] = 8'd1;
      7: begin mem[3] = 8'd9; mem[4] = 8'd9; end
      default: ;
    endcase
  endtask

  // Start in cycle 0 (the negedge where start is raised), observe cycles 1..38.
  task automatic scan(input string nm, input int pulse_at,
                      input logic [NL-1:0] eidx, input logic [VW-1:0] eval);
    int tim_err = 0;
    int hold_err = 0;
    int dcnt = 0;
    int dcyc = -1;
    logic [NL-1:0] ridx = '0;
    logic [VW-1:0] rval = '0;
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= 38; c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      if (rdEn !== (c >= 1 && c <= NG)) tim_err++;
      if (busy !== (c >= 1 && c <= NG + 1)) tim_err++;
      if (rdAddr !== ((c >= 1 && c <= NG) ? (NL-2)'(c - 1) : '0)) tim_err++;
      if (done === 1'b1) begin
        dcnt++;
        dcyc = c;
        ridx = maxIdx;
        rval = maxVal;
      end else if (c < NG + 2) begin
        if (maxIdx !== prev_idx || maxVal !== prev_val) hold_err++;
      end else if (maxIdx !== eidx || maxVal !== eval) begin
        hold_err++;
      end
    end
    start = 1'b0;
    check({nm, " done count"}, dcnt, 1);
    check({nm, " done cycle"}, dcyc, NG + 2);
    check({nm, " maxIdx"}, ridx, eidx);
    check({nm, " maxVal"}, rval, eval);
    check({nm, " strobe timing errors"}, tim_err, 0);
    check({nm, " result hold errors"}, hold_err, 0);
    prev_idx = eidx;
    prev_val = eval;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt, d1, d2;
    vecs[0] = '{"zeros",      0, -1, 7'd0,   8'd0};
    vecs[1] = '{"ramp",       1, -1, 7'd127, 8'd127};
    vecs[2] = '{"single77",   2, -1, 7'd77,  8'd200};
    vecs[3] = '{"ingrp_tie",  3, -1, 7'd40,  8'd250};
    vecs[4] = '{"xgrp_tie",   4, -1, 7'd5,   8'd255};
    vecs[5] = '{"start_c10",  1, 10, 7'd127, 8'd127};
    vecs[6] = '{"all255",     5, -1, 7'd0,   8'd255};
    vecs[7] = '{"last_only",  6, -1, 7'd127, 8'd1};
    vecs[8] = '{"lane3_lane0",7, -1, 7'd3,   8'd9};

    rst = 1'b1;
    start = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset rdEn", rdEn, 0);
    check("reset rdAddr", rdAddr, 0);
    check("reset done", done, 0);
    check("reset maxIdx", maxIdx, 0);
    check("reset maxVal", maxVal, 0);
    rst = 1'b0;
    prev_idx = '0;
    prev_val = '0;

    for (int v = 0; v < 9; v++) begin
      fill(vecs[v].pattern);
      scan(vecs[v].name, vecs[v].pulse_at, vecs[v].eidx, vecs[v].eval);
    end

    // start held high: second scan launches from the single IDLE cycle 35.
    fill(1);
    dcnt = 0; d1 = -1; d2 = -1;
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= 75; c++) begin
      @(negedge clk);
      if (c == 70) start = 1'b0;
      if (done === 1'b1) begin
        dcnt++;
        if (dcnt == 1) d1 = c; else d2 = c;
      end
    end
    check("b2b done count", dcnt, 2);
    check("b2b first done", d1, NG + 2);
    check("b2b second done", d2, 2 * NG + 5);
    check("b2b maxIdx", maxIdx, 127);

    // Reset in cycle 12 of a scan aborts it.
    fill(2);
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 12) rst = 1'b1;
    end
    @(negedge clk) rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort rdEn", rdEn, 0);
    check("abort rdAddr", rdAddr, 0);
    check("abort done", done, 0);
    check("abort maxIdx", maxIdx, 0);
    check("abort maxVal", maxVal, 0);
    dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    check("abort no done", dcnt, 0);
    prev_idx = '0;
    prev_val = '0;
    scan("restart", -1, 7'd77, 8'd200);

    // Reset wins over start in the same cycle.
    @(negedge clk) begin rst = 1'b1; start = 1'b1; end
    @(negedge clk) begin rst = 1'b0; start = 1'b0; end
    check("rst_vs_start busy", busy, 0);
    check("rst_vs_start rdEn", rdEn, 0);
    check("rst_vs_start maxVal", maxVal, 0);
    @(negedge clk);
    check("rst_vs_start idle", rdEn, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
